// File: rtl/vram_pkg.sv
// Shared types and default geometry for the HuC6270 VRAM model.
package vram_pkg;

  typedef enum logic {
    CLEAR,
    RUN
  } vram_state_t;

  localparam int unsigned VRAM_MA_W   = 16;
  localparam int unsigned VRAM_ADDR_W = 15;
  localparam int unsigned VRAM_DATA_W = 16;
  localparam int unsigned VRAM_NCH    = 3;

endpackage

// File: rtl/vram_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above ptr, advancing ptr past it.
module vram_rr_arb #(
  parameter int unsigned NCH = 3
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] req,
  input  logic           advance,
  output logic [NCH-1:0] gnt
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] sel;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sel   = ptr_q;
    cand  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      cand = PW'((32'(ptr_q) + i) % NCH);
      if (!found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        sel       = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) begin
      ptr_d = PW'((32'(sel) + 1) % NCH);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/vram_mp.sv
// Multi-channel VDC VRAM: round-robin shared single-port array with byte enables,
// configurable read latency and a zeroing sweep after every reset.
module vram_mp
  import vram_pkg::*;
#(
  parameter int unsigned ADDR_W   = VRAM_ADDR_W,
  parameter int unsigned DATA_W   = VRAM_DATA_W,
  parameter int unsigned NCH      = VRAM_NCH,
  parameter int unsigned READ_LAT = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NCH-1:0]                       req,
  input  logic [NCH-1:0]                       we,
  input  logic [NCH-1:0][VRAM_MA_W-1:0]        addr,
  input  logic [NCH-1:0][DATA_W-1:0]           wdata,
  input  logic [NCH-1:0][DATA_W/8-1:0]         be,
  output logic [NCH-1:0]                       gnt,
  output logic [NCH-1:0]                       rvalid,
  output logic [DATA_W-1:0]                    rdata,
  output logic                                 busy
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CW    = (NCH > 1) ? $clog2(NCH) : 1;

  vram_state_t       state_q, state_d;
  logic [ADDR_W-1:0] clr_q, clr_d;
  logic [NCH-1:0]    arb_req;

  logic              any_gnt;
  logic [CW-1:0]     g_idx;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [NB-1:0]     g_be;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [READ_LAT-1:0]             vld_q;
  logic [READ_LAT-1:0][CW-1:0]     ch_q;
  logic [READ_LAT-1:0][DATA_W-1:0] dat_q;

  // Upper MA bits alias onto the array, so they are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      clr_q   <= '0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    unique case (state_q)
      CLEAR: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    busy    = (state_q == CLEAR);
    arb_req = (state_q == RUN && !reset) ? req : '0;
    rvalid  = '0;
    if (vld_q[READ_LAT-1]) begin
      rvalid[ch_q[READ_LAT-1]] = 1'b1;
    end
  end

  assign rdata = dat_q[READ_LAT-1];

  vram_rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (arb_req),
    .advance(|gnt),
    .gnt    (gnt)
  );

  always_comb begin
    any_gnt = |gnt;
    g_idx   = '0;
    g_we    = 1'b0;
    g_addr  = '0;
    g_wdata = '0;
    g_be    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (gnt[i]) begin
        g_idx   = CW'(i);
        g_we    = we[i];
        g_addr  = addr[i][ADDR_W-1:0];
        g_wdata = wdata[i];
        g_be    = be[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == CLEAR) begin
        mem[clr_q] <= '0;
      end else if (any_gnt && g_we) begin
        for (int unsigned b = 0; b < NB; b++) begin
          if (g_be[b]) begin
            mem[g_addr][b*8 +: 8] <= g_wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Each stage's data only moves with a valid token, so rdata holds between reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      ch_q  <= '0;
      dat_q <= '0;
    end else begin
      vld_q[0] <= any_gnt && !g_we;
      if (any_gnt && !g_we) begin
        ch_q[0]  <= g_idx;
        dat_q[0] <= mem[g_addr];
      end
      for (int unsigned s = 1; s < READ_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          ch_q[s]  <= ch_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_vram_mp.sv
// Scoreboard bench: instance a (ADDR_W=15, READ_LAT=1) and instance b (ADDR_W=8, READ_LAT=2).
module tb_vram_mp;

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] data;
    logic [31:0] due;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset  [2];
  logic [2:0]        req    [2];
  logic [2:0]        we     [2];
  logic [2:0][15:0]  addr   [2];
  logic [2:0][15:0]  wdata  [2];
  logic [2:0][1:0]   be     [2];
  logic [2:0]        gnt    [2];
  logic [2:0]        rvalid [2];
  logic [15:0]       rdata  [2];
  logic              busy   [2];

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t q0[$];
  exp_t q1[$];

  always @(posedge clock) cyc <= cyc + 1;

  vram_mp #(.ADDR_W(15), .DATA_W(16), .NCH(3), .READ_LAT(1)) dut_a (
    .clock(clock), .reset(reset[0]), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .be(be[0]), .gnt(gnt[0]), .rvalid(rvalid[0]), .rdata(rdata[0]),
    .busy(busy[0])
  );

  vram_mp #(.ADDR_W(8), .DATA_W(16), .NCH(3), .READ_LAT(2)) dut_b (
    .clock(clock), .reset(reset[1]), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .be(be[1]), .gnt(gnt[1]), .rvalid(rvalid[1]), .rdata(rdata[1]),
    .busy(busy[1])
  );

  function automatic int unsigned lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int k, input int ch, input logic [15:0] d, input int unsigned due);
    exp_t e;
    e.ch   = 2'(ch);
    e.data = d;
    e.due  = due;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon(input int k);
    exp_t e;
    bit   empty;
    e = '0;
    if (k == 0) begin
      empty = (q0.size() == 0);
      if (!empty) e = q0.pop_front();
    end else begin
      empty = (q1.size() == 0);
      if (!empty) e = q1.pop_front();
    end
    if (empty) begin
      chk($sformatf("unexpected_rvalid_%0d", k), 32'(rvalid[k]), 32'd0);
    end else begin
      chk($sformatf("rvalid_ch_%0d", k), 32'(rvalid[k]), 32'd1 << e.ch);
      chk($sformatf("rdata_%0d", k), 32'(rdata[k]), 32'(e.data));
      chk($sformatf("rvalid_cycle_%0d", k), cyc, e.due);
    end
  endtask

  always @(negedge clock) begin
    if (rvalid[0] != 3'b000) mon(0);
    if (rvalid[1] != 3'b000) mon(1);
  end

  // One access on one channel: hold the request until granted, then release it.
  task automatic access(input int k, input int ch, input bit w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] b, input logic [15:0] exp_d);
    int n = 0;
    @(negedge clock);
    req[k][ch]   = 1'b1;
    we[k][ch]    = w;
    addr[k][ch]  = a;
    wdata[k][ch] = d;
    be[k][ch]    = b;
    #1;
    while (!gnt[k][ch] && n < 64) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk($sformatf("gnt_%0d_ch%0d", k, ch), 32'(gnt[k]), 32'd1 << ch);
    if (gnt[k][ch] && !w) push(k, ch, exp_d, cyc + lat(k));
    @(posedge clock);
    #1;
    req[k][ch] = 1'b0;
  endtask

  // Called at a negedge just after reset falls; counts edges until busy drops.
  task automatic wait_clear(input int k, input int unsigned exp_n, input string name);
    int unsigned n = 0;
    int unsigned g = 0;
    while (busy[k] && n < 70000) begin
      @(posedge clock);
      #1;
      n++;
      if (busy[k] && gnt[k] != 3'b000) g++;
    end
    req[k] = '0;
    chk({name, "_busy_cycles"}, n, exp_n);
    chk({name, "_gnt_while_busy"}, g, 0);
  endtask

  task automatic noop_req_all(input int k);
    req[k] = '1;
    we[k]  = '1;
    be[k]  = '0;
  endtask

  task automatic seq_a();
    int i0 = 0;
    int i1 = 0;
    int grants = 0;
    int bubbles = 0;
    wait_clear(0, 32768, "a_clear");
    access(0, 0, 1'b1, 16'h0000, 16'hDEAD, 2'b11, 16'h0);
    access(0, 1, 1'b1, 16'h1234, 16'hBEEF, 2'b11, 16'h0);
    access(0, 2, 1'b1, 16'h7FFF, 16'hCAFE, 2'b11, 16'h0);
    access(0, 0, 1'b0, 16'h1234, 16'h0, 2'b00, 16'hBEEF);
    repeat (3) @(negedge clock);
    noop_req_all(0);
    reset[0] = 1'b1;
    @(posedge clock);
    #1;
    chk("a_pulse_busy", 32'(busy[0]), 32'd1);
    chk("a_pulse_gnt", 32'(gnt[0]), 32'd0);
    @(negedge clock);
    reset[0] = 1'b0;
    wait_clear(0, 32768, "a_reclear");
    access(0, 0, 1'b0, 16'h0000, 16'h0, 2'b00, 16'h0000);
    access(0, 1, 1'b0, 16'h1234, 16'h0, 2'b00, 16'h0000);
    access(0, 2, 1'b0, 16'h7FFF, 16'h0, 2'b00, 16'h0000);
    access(0, 0, 1'b1, 16'h0100, 16'hABCD, 2'b11, 16'h0);
    access(0, 1, 1'b1, 16'h0100, 16'h1200, 2'b10, 16'h0);
    access(0, 2, 1'b0, 16'h0100, 16'h0, 2'b00, 16'h12CD);
    repeat (3) @(negedge clock);
    #1;
    chk("a_rdata_hold", 32'(rdata[0]), 32'h12CD);
    chk("a_rvalid_idle", 32'(rvalid[0]), 32'd0);
    chk("a_gnt_no_req", 32'(gnt[0]), 32'd0);
    access(0, 0, 1'b1, 16'h8005, 16'h5A5A, 2'b11, 16'h0);
    access(0, 2, 1'b0, 16'h0005, 16'h0, 2'b00, 16'h5A5A);
    // Last grant went to channel 2, so the pointer is back at 0.
    @(negedge clock);
    noop_req_all(0);
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("a_rr_all_%0d", i), 32'(gnt[0]), 32'd1 << (i % 3));
      @(negedge clock);
    end
    req[0] = 3'b100;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("a_rr_ch2_%0d", i), 32'(gnt[0]), 32'b100);
      @(negedge clock);
    end
    req[0] = '0;
    for (int i = 0; i < 16; i++) begin
      access(0, i % 3, 1'b1, 16'h0200 + 16'(i), 16'h1000 + 16'(i * 16'h0111), 2'b11, 16'h0);
    end
    @(negedge clock);
    for (int c = 0; c < 40 && (i0 < 8 || i1 < 8); c++) begin
      req[0][0]  = (i0 < 8);
      we[0][0]   = 1'b0;
      addr[0][0] = 16'h0200 + 16'(2 * i0);
      req[0][1]  = (i1 < 8);
      we[0][1]   = 1'b0;
      addr[0][1] = 16'h0200 + 16'(2 * i1 + 1);
      #1;
      if (gnt[0][0]) begin
        push(0, 0, 16'h1000 + 16'((2 * i0) * 16'h0111), cyc + 1);
        i0++;
        grants++;
      end else if (gnt[0][1]) begin
        push(0, 1, 16'h1000 + 16'((2 * i1 + 1) * 16'h0111), cyc + 1);
        i1++;
        grants++;
      end else begin
        bubbles++;
      end
      @(negedge clock);
    end
    req[0] = '0;
    chk("a_stream_grants", grants, 16);
    chk("a_stream_bubbles", bubbles, 0);
  endtask

  task automatic seq_b();
    wait_clear(1, 256, "b_clear");
    access(1, 0, 1'b1, 16'h0100, 16'hABCD, 2'b11, 16'h0);
    access(1, 1, 1'b1, 16'h0100, 16'h1200, 2'b10, 16'h0);
    access(1, 2, 1'b0, 16'h0100, 16'h0, 2'b00, 16'h12CD);
    repeat (4) @(negedge clock);
    // Read granted, then reset lands before it can reach rvalid.
    req[1][0]  = 1'b1;
    we[1][0]   = 1'b0;
    addr[1][0] = 16'h0040;
    #1;
    chk("b_midop_gnt", 32'(gnt[1]), 32'b001);
    @(posedge clock);
    #1;
    noop_req_all(1);
    reset[1] = 1'b1;
    #1;
    chk("b_gnt_in_reset", 32'(gnt[1]), 32'd0);
    @(posedge clock);
    #1;
    chk("b_reset_busy", 32'(busy[1]), 32'd1);
    chk("b_reset_gnt", 32'(gnt[1]), 32'd0);
    chk("b_reset_rvalid", 32'(rvalid[1]), 32'd0);
    @(negedge clock);
    reset[1] = 1'b0;
    wait_clear(1, 256, "b_reclear");
    access(1, 1, 1'b0, 16'h0100, 16'h0, 2'b00, 16'h0000);
    access(1, 2, 1'b0, 16'h00FF, 16'h0, 2'b00, 16'h0000);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      reset[k] = 1'b1;
      addr[k]  = '0;
      wdata[k] = '0;
      noop_req_all(k);
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_busy_%0d", k), 32'(busy[k]), 32'd1);
      chk($sformatf("rst_gnt_%0d", k), 32'(gnt[k]), 32'd0);
      chk($sformatf("rst_rvalid_%0d", k), 32'(rvalid[k]), 32'd0);
      chk($sformatf("rst_rdata_%0d", k), 32'(rdata[k]), 32'd0);
    end
    @(negedge clock);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    fork
      seq_a();
      seq_b();
    join
    repeat (5) @(negedge clock);
    chk("a_scoreboard_drained", q0.size(), 0);
    chk("b_scoreboard_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
